oled_init_seq: RTL and testbench
================================

Name: oled_init_seq

Overview:
Power-up/initialisation sequencer for the SSD1306-class OLED. It sits directly upstream of i2c_master and drives that core's command/data inputs.
On a start request it pulses the panel hardware reset, waits out the post-reset time, then streams a fixed command list to the panel as one I2C write transaction. It reports done or error to the top-level control logic.

Parameters:
RST_CYCLES, 1_000_000, clocks o_oled_rst_n is held low (10 ms at 100 MHz); minimum 1
POST_RST_CYCLES, 10_000, clocks waited after reset release before the I2C start; minimum 1
DEV_ADDR, 10'h03C, slave address presented to i2c_master
NUM_CMDS, 8, number of command bytes in the ROM; fixed at 8 for this revision

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  single-cycle request to run the init sequence
o_oled_rst_n  out  1  panel hardware reset, active low
o_busy  out  1  high from accepted start until DONE/ERROR
o_done  out  1  one-cycle pulse on successful completion
o_error  out  1  sticky NACK flag; cleared on the next accepted start
o_slave_addr  out  10  to i2c_master i_slave_addr; constant DEV_ADDR
o_byte_cnt  out  8  to i2c_master i_byte_cnt
o_control_reg  out  4  to i2c_master i_control_reg; bit3 = start
o_mode_reg  out  4  to i2c_master i_mode_reg; always 4'b0000 (write)
o_tx_data  out  8  to i2c_master i_tx_data
i_tx_data_needed  in  1  from i2c_master: current byte consumed, next byte requested
i_status_reg  in  5  from i2c_master: bit4 = transaction busy, bit3 = NACK received

Behaviour:
- Reset values (async, i_rst_n low): state IDLE, o_oled_rst_n=1, o_busy=0, o_done=0, o_error=0, o_byte_cnt=0, o_control_reg=0, o_tx_data=0, o_mode_reg=0, byte index=0, timer=0.
- Command ROM, index 0..7: AE, 8D, 14, 20, 00, A1, C8, AF.
- IDLE:
  - i_start=1 -> RST_LOW; clear o_error, set o_busy, load timer.
  - i_start while o_busy=1 is ignored in every state.
- RST_LOW: o_oled_rst_n=0 for exactly RST_CYCLES clocks, then -> RST_WAIT with o_oled_rst_n=1.
- RST_WAIT: count POST_RST_CYCLES clocks, then -> I2C_START.
- I2C_START (one cycle):
  - o_byte_cnt = NUM_CMDS+1 (=9), o_tx_data = 8'h00 (control byte, Co=0 D/C=0), o_control_reg = 4'b1000.
  - -> STREAM; o_control_reg returns to 4'b0000 the next cycle, so the start bit is high for exactly one clock.
- STREAM:
  - A rising edge of i_tx_data_needed (registered edge detect) while index < NUM_CMDS loads o_tx_data = ROM[index] the next cycle and increments index.
  - Edges seen once index == NUM_CMDS are ignored; o_tx_data holds AF.
  - Track a seen_busy flag, set when i_status_reg[4]=1.
  - Transaction completes when seen_busy=1, i_status_reg[4]=0 and index == NUM_CMDS -> DONE.
- Busy drops with index < NUM_CMDS: treat as a failed transfer -> ERROR.
- NACK (i_status_reg[3]=1 during STREAM): -> ERROR immediately; no further ROM bytes loaded.
- DONE: o_done=1 for one cycle, o_busy=0, -> IDLE.
- ERROR: o_error=1 (sticky), o_busy=0, -> IDLE.
- The I2C start occurs exactly RST_CYCLES+POST_RST_CYCLES+1 clocks after the cycle in which i_start is sampled.
- i_rst_n low mid-sequence aborts immediately: o_oled_rst_n returns to 1 and i2c_master start is not re-issued. The i2c_master shares the reset, so no bus cleanup is needed here.
- Undefined state encodings -> IDLE.

Test Plan:
1. Reset and idle: assert i_rst_n=0 mid-clock -> all outputs at their reset values asynchronously; no o_control_reg[3] pulse while idle.
2. Reset timing (RST_CYCLES=4, POST_RST_CYCLES=2): pulse i_start ->
   - o_oled_rst_n low for exactly 4 clocks;
   - o_control_reg=4'b1000 for one clock, 7 clocks after the start sample, with o_byte_cnt=9 and o_tx_data=00.
3. Full stream against an i2c_master model: 8 tx_data_needed pulses ->
   - o_tx_data sequence AE,8D,14,20,00,A1,C8,AF;
   - busy falls, then o_done pulses once and o_busy=0.
4. Handshake robustness: tx_data_needed held high for 3 clocks per request, plus a 9th spurious pulse -> each byte loaded once; o_tx_data stays AF; o_done still asserts.
5. NACK: model sets i_status_reg[3] after the 2nd byte -> o_error=1, o_busy=0, no further loads, no o_done. A subsequent i_start clears o_error and reruns the sequence.
6. Abort and ignore:
   - i_rst_n low during STREAM -> state IDLE, o_oled_rst_n=1;
   - i_start pulsed during RST_WAIT -> ignored, with start timing unchanged.

Source files
------------

// File: rtl/oled_init_seq.sv
// Power-up sequencer for an SSD1306-class OLED: pulses the panel reset, waits,
// then streams a fixed command list to i2c_master as a single write transaction.
module oled_init_seq #(
  parameter int         RST_CYCLES      = 1_000_000,
  parameter int         POST_RST_CYCLES = 10_000,
  parameter logic [9:0] DEV_ADDR        = 10'h03C,
  parameter int         NUM_CMDS        = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  output logic       o_oled_rst_n,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error,
  output logic [9:0] o_slave_addr,
  output logic [7:0] o_byte_cnt,
  output logic [3:0] o_control_reg,
  output logic [3:0] o_mode_reg,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_data_needed,
  input  logic [4:0] i_status_reg
);

  localparam int TMR_MAX = (RST_CYCLES > POST_RST_CYCLES) ? RST_CYCLES : POST_RST_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam logic [3:0] LAST_IDX = 4'(NUM_CMDS);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RST_LOW   = 3'd1;
  localparam logic [2:0] RST_WAIT  = 3'd2;
  localparam logic [2:0] I2C_START = 3'd3;
  localparam logic [2:0] STREAM    = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;
  localparam logic [2:0] ERROR     = 3'd6;

  logic [2:0]       state;
  logic [TMR_W-1:0] timer;
  logic [3:0]       idx;
  logic             need_q;
  logic             need_rise;
  logic             seen_busy;
  logic             i2c_busy;
  logic             i2c_nack;
  logic             unused_status;

  function automatic logic [7:0] cmd_rom(input logic [3:0] i);
    case (i)
      4'd0:    cmd_rom = 8'hAE;
      4'd1:    cmd_rom = 8'h8D;
      4'd2:    cmd_rom = 8'h14;
      4'd3:    cmd_rom = 8'h20;
      4'd4:    cmd_rom = 8'h00;
      4'd5:    cmd_rom = 8'hA1;
      4'd6:    cmd_rom = 8'hC8;
      4'd7:    cmd_rom = 8'hAF;
      default: cmd_rom = 8'h00;
    endcase
  endfunction

  assign o_slave_addr  = DEV_ADDR;
  assign o_mode_reg    = 4'b0000;
  assign i2c_busy      = i_status_reg[4];
  assign i2c_nack      = i_status_reg[3];
  assign need_rise     = i_tx_data_needed & ~need_q;
  assign unused_status = ^i_status_reg[2:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) need_q <= 1'b0;
    else          need_q <= i_tx_data_needed;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      timer         <= '0;
      idx           <= '0;
      seen_busy     <= 1'b0;
      o_oled_rst_n  <= 1'b1;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
      o_byte_cnt    <= 8'h00;
      o_control_reg <= 4'b0000;
      o_tx_data     <= 8'h00;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state        <= RST_LOW;
            o_error      <= 1'b0;
            o_busy       <= 1'b1;
            o_oled_rst_n <= 1'b0;
            timer        <= TMR_W'(RST_CYCLES - 1);
          end
        end
        RST_LOW: begin
          if (timer == '0) begin
            state        <= RST_WAIT;
            o_oled_rst_n <= 1'b1;
            timer        <= TMR_W'(POST_RST_CYCLES - 1);
          end else begin
            timer <= timer - 1'b1;
          end
        end
        RST_WAIT: begin
          if (timer == '0) state <= I2C_START;
          else             timer <= timer - 1'b1;
        end
        I2C_START: begin
          // Leading 0x00 is the SSD1306 control byte (Co=0, D/C=0): all commands follow.
          o_byte_cnt    <= 8'(NUM_CMDS + 1);
          o_tx_data     <= 8'h00;
          o_control_reg <= 4'b1000;
          idx           <= '0;
          seen_busy     <= 1'b0;
          state         <= STREAM;
        end
        STREAM: begin
          o_control_reg <= 4'b0000;
          if (i2c_busy) seen_busy <= 1'b1;
          if (i2c_nack) begin
            state   <= ERROR;
            o_error <= 1'b1;
            o_busy  <= 1'b0;
          end else if (seen_busy && !i2c_busy) begin
            // Master went idle: success only if every command byte was handed over.
            o_busy <= 1'b0;
            if (idx == LAST_IDX) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              state   <= ERROR;
              o_error <= 1'b1;
            end
          end else if (need_rise && (idx < LAST_IDX)) begin
            o_tx_data <= cmd_rom(idx);
            idx       <= idx + 1'b1;
          end
        end
        DONE:  state <= IDLE;
        ERROR: state <= IDLE;
        default: begin
          state         <= IDLE;
          o_busy        <= 1'b0;
          o_oled_rst_n  <= 1'b1;
          o_control_reg <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oled_init_seq.sv
// Directed bench for oled_init_seq with shortened reset timing and a hand-driven
// i2c_master handshake.
module tb_oled_init_seq;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic       i_start = 1'b0;
  logic       o_oled_rst_n, o_busy, o_done, o_error;
  logic [9:0] o_slave_addr;
  logic [7:0] o_byte_cnt, o_tx_data;
  logic [3:0] o_control_reg, o_mode_reg;
  logic       i_tx_data_needed = 1'b0;
  logic [4:0] i_status_reg = 5'b0;

  typedef struct {
    logic [7:0] exp_tx;
    int         hold;
  } vec_t;

  vec_t vt[8];
  int   n_vec = 0;
  int   n_err = 0;

  oled_init_seq #(
    .RST_CYCLES(4), .POST_RST_CYCLES(2), .DEV_ADDR(10'h03C), .NUM_CMDS(8)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .o_oled_rst_n(o_oled_rst_n), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_slave_addr(o_slave_addr), .o_byte_cnt(o_byte_cnt), .o_control_reg(o_control_reg),
    .o_mode_reg(o_mode_reg), .o_tx_data(o_tx_data),
    .i_tx_data_needed(i_tx_data_needed), .i_status_reg(i_status_reg)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: act=%0h req=%0h", name, act, exp);
    end
  endtask

  // Issue a start; optionally re-pulse i_start before edge ign_k (must be ignored).
  task automatic start_seq(input int ign_k);
    int low = 0;
    int pulse_at = -1;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("start_busy", 32'(o_busy), 32'd1);
    chk("start_err_clr", 32'(o_error), 32'd0);
    if (!o_oled_rst_n) low++;
    for (int k = 1; k <= 7; k++) begin
      i_start = (k == ign_k);
      step();
      i_start = 1'b0;
      if (!o_oled_rst_n) low++;
      if (o_control_reg[3] && pulse_at < 0) pulse_at = k;
    end
    chk("rst_low_clks", 32'(low), 32'd4);
    chk("start_pulse_at", 32'(pulse_at), 32'd7);
    chk("byte_cnt", 32'(o_byte_cnt), 32'd9);
    chk("ctrl_byte", 32'(o_tx_data), 32'h00);
    chk("slave_addr", 32'(o_slave_addr), 32'h03C);
    i_status_reg = 5'b10000;
    step();
    chk("start_one_clk", 32'(o_control_reg), 32'd0);
  endtask

  task automatic send_bytes(input int first, input int last, input int hold_ovr);
    for (int i = first; i <= last; i++) begin
      int h = (hold_ovr > 0) ? hold_ovr : vt[i].hold;
      i_tx_data_needed = 1'b1;
      repeat (h) step();
      i_tx_data_needed = 1'b0;
      step();
      chk($sformatf("tx_byte%0d", i), 32'(o_tx_data), 32'(vt[i].exp_tx));
    end
  endtask

  task automatic finish_ok();
    int dn = 0;
    chk("busy_in_stream", 32'(o_busy), 32'd1);
    i_status_reg = 5'b00000;
    for (int k = 0; k < 4; k++) begin
      step();
      dn += int'(o_done);
    end
    chk("done_pulses", 32'(dn), 32'd1);
    chk("busy_after_done", 32'(o_busy), 32'd0);
    chk("no_error", 32'(o_error), 32'd0);
  endtask

  initial begin
    int cnt;
    vt[0] = '{8'hAE, 1}; vt[1] = '{8'h8D, 2}; vt[2] = '{8'h14, 1}; vt[3] = '{8'h20, 3};
    vt[4] = '{8'h00, 1}; vt[5] = '{8'hA1, 2}; vt[6] = '{8'hC8, 1}; vt[7] = '{8'hAF, 1};

    // Test 1: asynchronous reset mid-clock, then idle.
    #3 i_rst_n = 1'b0;
    #1;
    chk("rst_oled_rst_n", 32'(o_oled_rst_n), 32'd1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_error", 32'(o_error), 32'd0);
    chk("rst_byte_cnt", 32'(o_byte_cnt), 32'd0);
    chk("rst_ctrl", 32'(o_control_reg), 32'd0);
    chk("rst_mode", 32'(o_mode_reg), 32'd0);
    chk("rst_tx", 32'(o_tx_data), 32'd0);
    step(); step();
    i_rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      cnt += int'(o_control_reg[3]) + int'(o_busy);
    end
    chk("idle_quiet", 32'(cnt), 32'd0);

    // Tests 2/3: timing and full stream with mixed handshake lengths.
    start_seq(0);
    send_bytes(0, 7, 0);
    finish_ok();

    // Test 4: long handshakes plus a spurious ninth request.
    step();
    start_seq(0);
    send_bytes(0, 7, 3);
    i_tx_data_needed = 1'b1;
    repeat (3) step();
    i_tx_data_needed = 1'b0;
    step();
    chk("spurious_hold_AF", 32'(o_tx_data), 32'hAF);
    finish_ok();

    // Test 5: NACK after the second byte, then restart.
    step();
    start_seq(0);
    send_bytes(0, 1, 0);
    i_status_reg = 5'b11000;
    step();
    chk("nack_error", 32'(o_error), 32'd1);
    chk("nack_busy", 32'(o_busy), 32'd0);
    i_status_reg = 5'b00000;
    cnt = 0;
    for (int k = 0; k < 2; k++) begin
      i_tx_data_needed = 1'b1;
      step();
      cnt += int'(o_done);
      i_tx_data_needed = 1'b0;
      step();
      cnt += int'(o_done);
    end
    chk("nack_no_load", 32'(o_tx_data), 32'h8D);
    chk("nack_no_done", 32'(cnt), 32'd0);
    chk("nack_sticky", 32'(o_error), 32'd1);
    start_seq(0);
    send_bytes(0, 7, 0);
    finish_ok();

    // Test 6: reset abort during stream, then ignored start during the post-reset wait.
    step();
    start_seq(0);
    send_bytes(0, 2, 0);
    i_rst_n = 1'b0;
    #2;
    chk("abort_oled_rst_n", 32'(o_oled_rst_n), 32'd1);
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_tx", 32'(o_tx_data), 32'd0);
    i_status_reg = 5'b00000;
    step();
    i_rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      cnt += int'(o_control_reg[3]) + int'(o_busy) + int'(!o_oled_rst_n);
    end
    chk("abort_idle", 32'(cnt), 32'd0);
    start_seq(5);
    send_bytes(0, 7, 0);
    finish_ok();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
